// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin arbiter with optional locked bursts, feeding a
// single registered output stage with a valid/ready handshake.
module bus_arbiter_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req_0,
  input  logic [WIDTH-1:0] data_0,
  input  logic             lock_0,
  output logic             gnt_0,

  input  logic             req_1,
  input  logic [WIDTH-1:0] data_1,
  input  logic             lock_1,
  output logic             gnt_1,

  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             prio;
  logic             run;
  logic             load_en;
  logic             beat;
  logic             sel;
  logic             sel_lock;
  logic [WIDTH-1:0] sel_data;

  // The output stage can take a word whenever it is empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Exactly one grant can be high, so gnt_1 alone identifies the source.
  assign beat     = (gnt_0 && req_0) || (gnt_1 && req_1);
  assign sel      = gnt_1;
  assign sel_data = sel ? data_1 : data_0;
  assign sel_lock = sel ? lock_1 : lock_0;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: an accepted beat decides ownership for the next cycle.
  // NOTE: the default assignment at the top of each combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (beat) begin
      if (sel_lock) begin
        state_next = sel ? OWN1 : OWN0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Grant logic. Grants stay low until reset has been released at a clock edge
  // (run), and while the output stage cannot accept a word.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (run && load_en) begin
      case (state)
        IDLE: begin
          if (req_0 && req_1) begin
            gnt_0 = !prio;
            gnt_1 = prio;
          end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
          end
        end
        OWN0:    gnt_0 = req_0;
        OWN1:    gnt_1 = req_1;
        default: begin
          gnt_0 = 1'b0;
          gnt_1 = 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer, run flag and output register.
  // NOTE: the data register is reset along with the control state because a
  // defined out_data of zero is part of the reset behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      prio      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (beat) begin
        prio      <= !sel;
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1: the stimulus pushes expected words into
// a scoreboard queue and an independent monitor pops them as the DUT drains.
module tb_bus_arbiter_2to1;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req_0;
  logic [WIDTH-1:0] data_0;
  logic             lock_0;
  logic             gnt_0;
  logic             req_1;
  logic [WIDTH-1:0] data_1;
  logic             lock_1;
  logic             gnt_1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             src;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  bus_arbiter_2to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_0     (req_0),
    .data_0    (data_0),
    .lock_0    (lock_0),
    .gnt_0     (gnt_0),
    .req_1     (req_1),
    .data_1    (data_1),
    .lock_1    (lock_1),
    .gnt_1     (gnt_1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.src  = s;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word held with out_ready high at the falling edge is consumed
  // at the next rising edge, since inputs only change just after rising edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got word 0x%08h src %0d, expected no word at %0t",
                   out_data, out_src, $time);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_src", {31'd0, out_src}, {31'd0, e.src});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c1;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_0     = 1'b0;
    req_1     = 1'b0;
    data_0    = '0;
    data_1    = '0;
    lock_0    = 1'b0;
    lock_1    = 1'b0;
    out_ready = 1'b0;

    // ---- Reset with random inputs ----
    for (int i = 0; i < 4; i++) begin
      tick();
      req_0     = 1'($urandom_range(0, 1));
      req_1     = 1'($urandom_range(0, 1));
      lock_0    = 1'($urandom_range(0, 1));
      lock_1    = 1'($urandom_range(0, 1));
      data_0    = $urandom;
      data_1    = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rst_gnt_0", {31'd0, gnt_0}, 32'd0);
      check("rst_gnt_1", {31'd0, gnt_1}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_src", {31'd0, out_src}, 32'd0);
    end
    req_0     = 1'b0;
    req_1     = 1'b0;
    lock_0    = 1'b0;
    lock_1    = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // ---- Contention: strict alternation starting with requester 0 ----
    c0    = 0;
    c1    = 0;
    req_0 = 1'b1;
    req_1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_0 = 32'hA000_0000 + c0;
      data_1 = 32'hB000_0000 + c1;
      #1;
      if (k % 2 == 0) begin
        check("cont_gnt_0", {31'd0, gnt_0}, 32'd1);
        check("cont_gnt_1", {31'd0, gnt_1}, 32'd0);
        push(32'hA000_0000 + c0, 1'b0);
        c0++;
      end else begin
        check("cont_gnt_0", {31'd0, gnt_0}, 32'd0);
        check("cont_gnt_1", {31'd0, gnt_1}, 32'd1);
        push(32'hB000_0000 + c1, 1'b1);
        c1++;
      end
      tick();
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    tick();

    // ---- Single requester (prio back at 0) ----
    req_0  = 1'b1;
    data_0 = 32'h1111_1111;
    lock_0 = 1'b0;
    #1;
    check("single_gnt_0", {31'd0, gnt_0}, 32'd1);
    check("single_gnt_1", {31'd0, gnt_1}, 32'd0);
    push(32'h1111_1111, 1'b0);
    tick();
    req_0 = 1'b0;
    #1;
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    check("single_out_data", out_data, 32'h1111_1111);
    check("single_out_src", {31'd0, out_src}, 32'd0);
    tick();

    // ---- Back-pressure (prio now 1) ----
    out_ready = 1'b0;
    req_0     = 1'b1;
    data_0    = 32'hD000_0000;
    req_1     = 1'b1;
    data_1    = 32'hD000_0001;
    #1;
    check("bp_fill_gnt_1", {31'd0, gnt_1}, 32'd1);
    check("bp_fill_gnt_0", {31'd0, gnt_0}, 32'd0);
    push(32'hD000_0001, 1'b1);
    tick();
    data_1 = 32'hD000_0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_gnt_0", {31'd0, gnt_0}, 32'd0);
      check("bp_gnt_1", {31'd0, gnt_1}, 32'd0);
      check("bp_hold", out_data, 32'hD000_0001);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_gnt_0", {31'd0, gnt_0}, 32'd1);
    check("bp_release_gnt_1", {31'd0, gnt_1}, 32'd0);
    push(32'hD000_0000, 1'b0);
    tick();
    req_0 = 1'b0;
    #1;
    check("bp_same_edge_data", out_data, 32'hD000_0000);
    check("bp_next_gnt_1", {31'd0, gnt_1}, 32'd1);
    push(32'hD000_0011, 1'b1);
    tick();
    req_1 = 1'b0;
    tick();

    // ---- Locked burst from requester 1 (prio now 0) ----
    req_1  = 1'b1;
    data_1 = 32'h0000_00C1;
    lock_1 = 1'b1;
    #1;
    check("lock_c1_gnt_1", {31'd0, gnt_1}, 32'd1);
    push(32'h0000_00C1, 1'b1);
    tick();
    req_1  = 1'b0;
    req_0  = 1'b1;
    data_0 = 32'h0000_00E0;
    lock_0 = 1'b0;
    #1;
    check("lock_dip1_gnt_0", {31'd0, gnt_0}, 32'd0);
    check("lock_dip1_gnt_1", {31'd0, gnt_1}, 32'd0);
    tick();
    req_1  = 1'b1;
    data_1 = 32'h0000_00C2;
    lock_1 = 1'b1;
    #1;
    check("lock_c2_gnt_1", {31'd0, gnt_1}, 32'd1);
    check("lock_c2_gnt_0", {31'd0, gnt_0}, 32'd0);
    push(32'h0000_00C2, 1'b1);
    tick();
    req_1 = 1'b0;
    #1;
    check("lock_dip2_gnt_0", {31'd0, gnt_0}, 32'd0);
    tick();
    req_1  = 1'b1;
    data_1 = 32'h0000_00C3;
    lock_1 = 1'b0;
    #1;
    check("lock_c3_gnt_1", {31'd0, gnt_1}, 32'd1);
    check("lock_c3_gnt_0", {31'd0, gnt_0}, 32'd0);
    push(32'h0000_00C3, 1'b1);
    tick();
    req_1 = 1'b0;
    #1;
    check("lock_after_gnt_0", {31'd0, gnt_0}, 32'd1);
    push(32'h0000_00E0, 1'b0);
    tick();
    req_0 = 1'b0;
    tick();

    // ---- Reset mid-burst (prio now 1, so requester 1 wins) ----
    out_ready = 1'b0;
    req_1     = 1'b1;
    data_1    = 32'h0000_00F1;
    lock_1    = 1'b1;
    #1;
    check("mid_gnt_1", {31'd0, gnt_1}, 32'd1);
    tick();
    req_1 = 1'b0;
    #1;
    check("mid_held_valid", {31'd0, out_valid}, 32'd1);
    req_0 = 1'b1;
    req_1 = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_gnt_0", {31'd0, gnt_0}, 32'd0);
    check("mid_rst_gnt_1", {31'd0, gnt_1}, 32'd0);
    tick();
    req_0     = 1'b0;
    req_1     = 1'b0;
    lock_1    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    tick();
    req_0  = 1'b1;
    data_0 = 32'h1234_0000;
    req_1  = 1'b1;
    data_1 = 32'h5678_0000;
    #1;
    check("post_rst_gnt_0", {31'd0, gnt_0}, 32'd1);
    check("post_rst_gnt_1", {31'd0, gnt_1}, 32'd0);
    push(32'h1234_0000, 1'b0);
    tick();
    req_0 = 1'b0;
    #1;
    check("post_rst_next_gnt_1", {31'd0, gnt_1}, 32'd1);
    push(32'h5678_0000, 1'b1);
    tick();
    req_1 = 1'b0;
    tick();
    tick();
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2to1.md
# bus_arbiter_2to1

Two-requester, round-robin arbiter that shares one 32-bit data path between two sources. Each requester presents a word with a valid/ready-style request/grant handshake. The arbiter selects one requester per cycle through a 2:1 word select, registers the selected word in a single output stage, and offers it downstream with a valid/ready handshake. Optional locked bursts give one requester exclusive ownership across consecutive beats.

## Interface
- WIDTH, 32, data word width in bits.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_0  input  1  requester 0 has a word on data_0; lock_0 is also valid.
- data_0  input  WIDTH  requester 0 word.
- lock_0  input  1  keep ownership after this beat.
- gnt_0  output  1  combinational; the beat from requester 0 is accepted at this rising edge.
- req_1, data_1, lock_1, gnt_1: same as above, for requester 1.
- out_valid  output  1  out_data holds a word.
- out_data  output  WIDTH  registered word.
- out_src  output  1  registered source of out_data (0 or 1).
- out_ready  input  1  downstream accepts out_data at this edge.

## Operation
- The output stage loads when load_en = !out_valid || out_ready. Throughput is one word per cycle.
- A beat transfers from requester i at a rising edge when gnt_i && req_i. Requester i holds req_i, data_i and lock_i stable until it sees gnt_i.
- gnt_i is never asserted without req_i. gnt_0 and gnt_1 are mutually exclusive.
- Ownership FSM states are IDLE, OWN0 and OWN1.
  - IDLE: arbitration runs only while load_en is high.
    - Exactly one req: grant it.
    - Both reqs: grant the requester selected by prio (round-robin pointer).
  - OWNi: only requester i can be granted, while load_en && req_i. The other requester is blocked even if requester i is idle.
  - Transition: a beat from i accepted with lock_i=1 moves the FSM to OWNi, or keeps it there.
  - Transition: a beat from i accepted with lock_i=0 moves the FSM to IDLE.
- prio updates on every accepted beat to !i, the source just granted. It is unchanged when no beat is accepted.
- On an accepted beat from i:
  - out_data ← data_i, out_src ← i, out_valid ← 1.
- When out_ready && out_valid and no beat is accepted, out_valid ← 0. out_data and out_src keep their last values.
- Drain and load may happen in the same cycle. out_valid stays 1 and the new word replaces the old one.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, prio=0, out_valid=0, out_data=0, out_src=0. gnt_0 and gnt_1 are 0 while in reset.
- Latency: a word granted at edge N appears on out_data/out_valid immediately after edge N (one-cycle register latency).
- Back-pressure: while out_valid=1 and out_ready=0, both grants are 0 and out_data is held stable.
- A requester that raises req in the same cycle the other is granted waits at least one cycle.
- When both requesters are continuously requesting with lock=0, grants alternate 0,1,0,1… starting with 0 after reset.
- Reset asserted mid-burst (OWNi) returns the FSM to IDLE and drops any held word. No grant is issued until rst_n has been high at a rising edge.
- Steady state has no combinational path from out_ready to out_valid. gnt_i depends combinationally on out_ready, req_0, req_1, the FSM state and prio.

## Test plan
- Reset check:
  - Stimulus: rst_n low with random inputs, then release.
  - Required: out_valid=0, out_data=0, out_src=0, gnt_0=gnt_1=0 during reset; first grant possible at the first edge after release.
- Single requester:
  - Stimulus: req_0=1, data_0=0x11111111, lock_0=0, out_ready=1.
  - Required: gnt_0=1 in that cycle; next cycle out_valid=1, out_data=0x11111111, out_src=0.
- Contention:
  - Stimulus: req_0 and req_1 held high with data_0=0xA0000000+k and data_1=0xB0000000+k, out_ready=1.
  - Required: out_src sequence 0,1,0,1 with one word per cycle; no word lost or duplicated.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles with both requests high.
  - Required: no grants; out_data stays constant. The first edge with out_ready=1 drains and loads in the same cycle.
- Locked burst:
  - Stimulus: requester 1 sends 3 beats (0xC1, 0xC2, 0xC3) with lock_1=1,1,0 while req_0 is high.
  - Required: out_data sequence 0xC1, 0xC2, 0xC3, then requester 0's word. gnt_0 stays 0 during the burst, including the cycles where req_1 dips low.
- Reset mid-burst:
  - Stimulus: assert rst_n during OWN1 with out_valid=1.
  - Required: out_valid drops to 0 immediately. After release, requester 0 wins the first simultaneous request (prio=0).
